// File: rtl/alu_muldiv_if.sv
// Request/response bundle between the control unit and the multiply/divide unit.
interface alu_muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit with HI/LO registers (one bit per cycle).
// Operands are reduced to magnitudes at start, the core runs unsigned
// shift-add / restoring division, and signs are applied in FIX.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        rst,
    alu_muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    // Latched per-operation control
    typedef struct packed {
        logic is_div;
        logic neg_lo;   // product sign (mult) or quotient sign (div)
        logic neg_hi;   // remainder sign: follows the dividend
        logic bzero;    // divisor was zero
    } ctl_t;

    state_t           state, state_nxt;
    ctl_t             ctl;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;  // product high half / partial remainder
    logic [WIDTH-1:0] acc_lo;  // multiplier (shifting out) / dividend->quotient
    logic [WIDTH-1:0] opd;     // multiplicand / divisor magnitude
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             dbz_q;
    logic             accept, mt_ok;

    // Operand conditioning: unsigned ops (op[0]=1) use raw values
    logic             sgn, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign sgn   = ~bus.op[0];
    assign a_neg = sgn & bus.a[WIDTH-1];
    assign b_neg = sgn & bus.b[WIDTH-1];
    assign a_mag = a_neg ? -bus.a : bus.a;
    assign b_mag = b_neg ? -bus.b : bus.b;

    // Single-iteration step for both algorithms. The partial remainder is
    // always below the divisor, so it fits WIDTH bits; only the shifted
    // value needs the extra bit for the compare.
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH-1:0] diff;
    logic             ge;
    assign sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
    assign shl  = {acc_hi, acc_lo[WIDTH-1]};
    assign ge   = shl >= {1'b0, opd};
    assign diff = shl[WIDTH-1:0] - opd;

    // Sign fix-up of the raw magnitude results
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s, fix_hi, fix_lo;
    always_comb begin
        prod   = {acc_hi, acc_lo};
        prod_s = ctl.neg_lo ? -prod : prod;
        quo_s  = ctl.neg_lo ? -acc_lo : acc_lo;
        // With b == 0 the remainder is |a|; re-applying a's sign gives a back
        rem_s  = ctl.neg_hi ? -acc_hi : acc_hi;
        if (ctl.is_div) begin
            fix_hi = rem_s;
            fix_lo = ctl.bzero ? '1 : quo_s;
        end else begin
            fix_hi = prod_s[2*WIDTH-1:WIDTH];
            fix_lo = prod_s[WIDTH-1:0];
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = CALC;
            CALC: if (cnt == CW'(1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = bus.start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs and strobes
    always_comb begin
        bus.busy = (state == CALC) || (state == FIX);
        bus.done = (state == DONE);
        accept   = bus.start && ((state == IDLE) || (state == DONE));
        mt_ok    = !bus.start && ((state == IDLE) || (state == DONE));
    end

    // Iteration datapath: load magnitudes on accept, one step per CALC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctl    <= '0;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opd    <= '0;
        end else if (accept) begin
            ctl.is_div <= bus.op[1];
            ctl.neg_lo <= a_neg ^ b_neg;
            ctl.neg_hi <= a_neg;
            ctl.bzero  <= (bus.b == '0);
            cnt        <= CW'(WIDTH);
            acc_hi     <= '0;
            acc_lo     <= bus.op[1] ? a_mag : b_mag;
            opd        <= bus.op[1] ? b_mag : a_mag;
        end else if (state == CALC) begin
            cnt <= cnt - CW'(1);
            if (ctl.is_div) begin
                acc_hi <= ge ? diff : shl[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], ge};
            end else begin
                acc_hi <= sum[WIDTH:1];
                acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
            end
        end
    end

    // HI/LO: result write in FIX, mthi/mtlo only when idle and not starting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == FIX) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
        end else if (mt_ok) begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
        end
    end

    // Divide-by-zero flag, sticky until the next accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                        dbz_q <= 1'b0;
        else if (accept)                                dbz_q <= 1'b0;
        else if (state == FIX && ctl.is_div && ctl.bzero) dbz_q <= 1'b1;
    end

    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;
endmodule
